// File: rtl/sa_mover_pkg.sv
// Shared types and helpers for the systolic-array output drain stage.
// The control FSM encoding and the lane-slice arithmetic live here.
package sa_mover_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width needed to hold a tile count from 0 up to max_tiles inclusive.
  function automatic int tile_width(input int max_tiles);
    return $clog2(max_tiles + 1);
  endfunction

  // Lane 0 occupies the most significant slice of a packed row.
  function automatic int lane_lsb(input int lane, input int lanes, input int width);
    return (lanes - 1 - lane) * width;
  endfunction

endpackage

// File: rtl/sa_data_mover_v3_skew.sv
// Skew line: lane i sees the lane-0 read enable and buffer row index
// delayed by i cycles.
module sa_skew_delay #(
  parameter int LANES = 16,
  parameter int IDX_W = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [IDX_W-1:0]            idx,
  output logic [LANES-1:0]            lane_en,
  output logic [LANES-1:0][IDX_W-1:0] lane_idx
);

  logic [LANES-1:1]            sr_en;
  logic [LANES-1:1][IDX_W-1:0] sr_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_en  <= '0;
      sr_idx <= '0;
    end else begin
      sr_en[1]  <= en;
      sr_idx[1] <= idx;
      for (int i = 2; i < LANES; i++) begin
        sr_en[i]  <= sr_en[i-1];
        sr_idx[i] <= sr_idx[i-1];
      end
    end
  end

  always_comb begin
    lane_en     = {sr_en, en};
    lane_idx    = '0;
    lane_idx[0] = idx;
    for (int i = 1; i < LANES; i++) lane_idx[i] = sr_idx[i];
  end

endmodule

// File: rtl/sa_data_mover_v3.sv
// Drain stage: skewed FIFO reads de-skewed into a ping-pong transpose buffer,
// then written to memory one row per cycle from a runtime base address.
module sa_data_mover_v3
  import sa_mover_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PE_SIZE    = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_TILES  = 64,
  localparam int TILE_W    = tile_width(MAX_TILES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [TILE_W-1:0]             num_tiles_i,
  input  logic [ADDR_WIDTH-1:0]         base_addr_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [PE_SIZE-1:0]            rden_o,
  input  logic [DATA_WIDTH*PE_SIZE-1:0] rdata_i,
  output logic [DATA_WIDTH*PE_SIZE-1:0] mem_d_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic                          mem_ce_o,
  output logic                          mem_we_o
);

  localparam int RW    = $clog2(PE_SIZE);
  localparam int IW    = RW + 1;
  localparam int DEPTH = 2 ** IW;

  state_t                     state, state_nxt;
  logic [TILE_W-1:0]          tiles_left;
  logic [RW-1:0]              cap_row;
  logic                       cap_bank;
  logic                       drain_active;
  logic [RW-1:0]              drain_row;
  logic                       drain_bank;
  logic [ADDR_WIDTH-1:0]      drain_addr;
  logic                       accept, cap_en, cap_last, last_cap, bank_full, drain_last;
  logic [PE_SIZE-1:0]         lane_en;
  logic [PE_SIZE-1:0][IW-1:0] lane_idx;
  logic [DATA_WIDTH-1:0]      tbuf [DEPTH][PE_SIZE];

  assign accept     = start_i && !busy_o;
  assign cap_en     = (state == RUN);
  assign cap_last   = cap_en && (cap_row == RW'(PE_SIZE - 1));
  assign last_cap   = cap_last && (tiles_left == TILE_W'(1));
  assign drain_last = (drain_row == RW'(PE_SIZE - 1));
  // The last lane reading its last row means the whole bank is now filled.
  assign bank_full  = lane_en[PE_SIZE-1] && (lane_idx[PE_SIZE-1][RW-1:0] == RW'(PE_SIZE - 1));

  sa_skew_delay #(
    .LANES (PE_SIZE),
    .IDX_W (IW)
  ) u_skew (
    .clk      (clk),
    .rst      (rst),
    .en       (cap_en),
    .idx      ({cap_bank, cap_row}),
    .lane_en  (lane_en),
    .lane_idx (lane_idx)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = (num_tiles_i == '0) ? DONE : RUN;
        else        state_nxt = IDLE;
      end
      RUN:     if (last_cap) state_nxt = FLUSH;
      FLUSH:   if (drain_active && drain_last && !bank_full) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tiles_left   <= '0;
      cap_row      <= '0;
      cap_bank     <= 1'b0;
      drain_active <= 1'b0;
      drain_row    <= '0;
      drain_bank   <= 1'b0;
      drain_addr   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        tiles_left <= num_tiles_i;
        cap_row    <= '0;
        cap_bank   <= 1'b0;
      end else if (cap_last) begin
        cap_row    <= '0;
        cap_bank   <= ~cap_bank;
        tiles_left <= tiles_left - 1'b1;
      end else if (cap_en) begin
        cap_row <= cap_row + 1'b1;
      end
      // A newly full bank restarts the drain, so back-to-back tiles write without a gap.
      if (bank_full) begin
        drain_active <= 1'b1;
        drain_row    <= '0;
        drain_bank   <= lane_idx[PE_SIZE-1][RW];
      end else if (drain_active) begin
        if (drain_last) drain_active <= 1'b0;
        else            drain_row    <= drain_row + 1'b1;
      end
      if (accept)            drain_addr <= base_addr_i;
      else if (drain_active) drain_addr <= drain_addr + 1'b1;
    end
  end

  // Row r of a bank is always drained before the next capture into that bank reaches it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PE_SIZE; i++) begin
      if (lane_en[i]) tbuf[lane_idx[i]][i] <= rdata_i[lane_lsb(i, PE_SIZE, DATA_WIDTH) +: DATA_WIDTH];
    end
  end

  always_comb begin
    mem_d_o = '0;
    for (int i = 0; i < PE_SIZE; i++) begin
      mem_d_o[lane_lsb(i, PE_SIZE, DATA_WIDTH) +: DATA_WIDTH] = tbuf[{drain_bank, drain_row}][i];
    end
  end

  assign rden_o     = lane_en;
  assign mem_ce_o   = drain_active;
  assign mem_we_o   = drain_active;
  assign mem_addr_o = drain_addr;
  assign busy_o     = (state == RUN) || (state == FLUSH);
  assign done_o     = (state == DONE);

endmodule

// File: tb/tb_sa_data_mover_v3.sv
// Bench for sa_data_mover_v3: lane FIFO model feeds the DUT, expected memory
// writes are queued per run and matched by an independent monitor.
module tb_sa_data_mover_v3;

  localparam int P  = 4;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int MT = 64;
  localparam int TW = $clog2(MT + 1);
  localparam int EW = 16 + AW + P * DW;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_i;
  logic [TW-1:0]   num_tiles_i;
  logic [AW-1:0]   base_addr_i;
  logic            busy_o, done_o;
  logic [P-1:0]    rden_o;
  logic [P*DW-1:0] rdata_i;
  logic [P*DW-1:0] mem_d_o;
  logic [AW-1:0]   mem_addr_o;
  logic            mem_ce_o, mem_we_o;

  logic [DW-1:0] lane_q [P][$];
  logic [EW-1:0] exp_q[$];
  int            checks, errors;
  int            edge_cnt = 0;
  int            run_t0, run_n, done_seen;
  bit            run_on, mon_en;
  logic [P-1:0]  rd_seen = '0;

  sa_data_mover_v3 #(
    .DATA_WIDTH (DW),
    .PE_SIZE    (P),
    .ADDR_WIDTH (AW),
    .MAX_TILES  (MT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .num_tiles_i (num_tiles_i),
    .base_addr_i (base_addr_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rden_o      (rden_o),
    .rdata_i     (rdata_i),
    .mem_d_o     (mem_d_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ce_o    (mem_ce_o),
    .mem_we_o    (mem_we_o)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic drive_rdata();
    for (int i = 0; i < P; i++)
      rdata_i[(P-1-i)*DW +: DW] = (lane_q[i].size() != 0) ? lane_q[i][0] : '0;
  endtask

  // FWFT FIFO model: a lane pops after each cycle in which its enable was high.
  initial begin
    forever begin
      @(posedge clk);
      edge_cnt++;
      #1;
      for (int i = 0; i < P; i++) begin
        if (rd_seen[i]) begin
          if (lane_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL fifo_underflow: lane %0d read while empty", i);
          end else begin
            void'(lane_q[i].pop_front());
          end
        end
      end
      drive_rdata();
    end
  end

  // Monitor: timing windows from the run parameters, writes from the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      rd_seen = rden_o;
      if (mon_en) begin
        int            r;
        logic [P-1:0]  er;
        logic          eb, ed, ec;
        logic [15:0]   r16;
        logic [EW-1:0] item;
        r = edge_cnt - run_t0 + 1;
        for (int i = 0; i < P; i++) er[i] = run_on && (r >= 1 + i) && (r <= run_n * P + i);
        eb = run_on && (run_n > 0) && (r >= 1) && (r <= (run_n + 2) * P - 1);
        ed = run_on && (r == ((run_n == 0) ? 1 : (run_n + 2) * P));
        ec = run_on && (run_n > 0) && (r >= 2 * P) && (r <= (run_n + 2) * P - 1);
        check("rden", rden_o, er);
        check("busy", busy_o, eb);
        check("done", done_o, ed);
        check("mem_ce", mem_ce_o, ec);
        check("mem_we", mem_we_o, ec);
        if (done_o) done_seen++;
        if (mem_ce_o) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL write: unexpected write addr %0h data %0h", mem_addr_o, mem_d_o);
          end else begin
            item = exp_q.pop_front();
            r16  = r[15:0];
            check("write{cycle,addr,data}", {r16, mem_addr_o, mem_d_o}, item);
          end
        end
      end
    end
  end

  task automatic run_case(input int n, input logic [AW-1:0] base, input bit pattern,
                          input int extra_start, input int rst_cyc);
    logic [P*DW-1:0] w;
    logic [DW-1:0]   d;
    int              dc, r, left;
    @(negedge clk); #2;
    for (int k = 0; k < n; k++) begin
      for (int rr = 0; rr < P; rr++) begin
        for (int i = 0; i < P; i++) begin
          d = pattern ? DW'(rr * 16 + i) : DW'($urandom_range(0, 255));
          lane_q[i].push_back(d);
          w[(P-1-i)*DW +: DW] = d;
        end
        exp_q.push_back({16'((k + 2) * P + rr), AW'(base + k * P + rr), w});
      end
    end
    drive_rdata();
    done_seen   = 0;
    run_n       = n;
    run_t0      = edge_cnt + 1;
    run_on      = 1;
    start_i     = 1'b1;
    num_tiles_i = TW'(n);
    base_addr_i = base;
    dc = (n == 0) ? 1 : (n + 2) * P;
    @(negedge clk); #2;
    start_i     = 1'b0;
    num_tiles_i = TW'($urandom_range(0, MT));
    base_addr_i = AW'($urandom);
    for (int c = 0; c < dc + 3; c++) begin
      r = edge_cnt - run_t0 + 1;
      start_i = (r == extra_start);
      if (r == rst_cyc) begin
        rst    = 1'b1;
        run_on = 0;
        exp_q.delete();
        @(negedge clk); #2;
        check("abort_addr", mem_addr_o, 0);
        check("abort_ce", mem_ce_o, 0);
        rst = 1'b0;
        for (int i = 0; i < P; i++) lane_q[i].delete();
        drive_rdata();
        return;
      end
      @(negedge clk); #2;
    end
    start_i = 1'b0;
    left = 0;
    for (int i = 0; i < P; i++) left += lane_q[i].size();
    check("done_count", done_seen, 1);
    check("writes_left", exp_q.size(), 0);
    check("fifo_left", left, 0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; num_tiles_i = '0; base_addr_i = '0; rdata_i = '0;
    checks = 0; errors = 0; run_on = 0; run_n = 0; run_t0 = 0; done_seen = 0; mon_en = 0;
    repeat (3) @(negedge clk);
    #2;
    mon_en = 1;
    check("reset_addr", mem_addr_o, 0);
    check("reset_ce", mem_ce_o, 0);
    check("reset_rden", rden_o, 0);
    rst = 1'b0;

    run_case(1, AW'('h10), 1, -1, -1);
    run_case(3, AW'($urandom), 0, -1, -1);
    run_case(0, AW'($urandom), 0, -1, -1);
    run_case(1, AW'('h3FE), 0, -1, -1);
    run_case(1, AW'($urandom), 0, 5, -1);
    run_case(2, AW'($urandom), 0, -1, 9);
    run_case(2, AW'($urandom), 0, -1, -1);
    repeat (4) run_case($urandom_range(1, 5), AW'($urandom), 0, -1, -1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sa_data_mover_v3.md
# sa_data_mover_v3

Parametrised drain stage between the systolic-array output FIFOs and the output memory. It issues skewed read enables to the PE_SIZE column FIFOs and de-skews each PE_SIZE×PE_SIZE output tile into a ping-pong transpose buffer. It then writes the tile to memory one full row per cycle at a runtime base address. Runtime tile count, start/busy/done handshake and overlapped capture/drain give one tile per PE_SIZE cycles in steady state.

## Interface
- DATA_WIDTH, 8, width of one PE output element
- PE_SIZE, 16, lanes per row and rows per tile (≥2)
- ADDR_WIDTH, 10, memory address width
- MAX_TILES, 64, largest num_tiles_i; TILE_W = $clog2(MAX_TILES+1)
- clk  in  1  clock
- rst  in  1  reset: one clock; reset is synchronous and active-high
- start_i  in  1  start pulse, sampled only when idle
- num_tiles_i  in  TILE_W  tiles to move, latched on accepted start
- base_addr_i  in  ADDR_WIDTH  first memory address, latched on accepted start
- busy_o  out  1  high from cycle after accepted start through final write
- done_o  out  1  one-cycle pulse after final write
- rden_o  out  PE_SIZE  FIFO read enable, bit i = lane i
- rdata_i  in  DATA_WIDTH*PE_SIZE  FWFT FIFO data; lane 0 in MSBs
- mem_d_o  out  DATA_WIDTH*PE_SIZE  write data; lane 0 in MSBs
- mem_addr_o  out  ADDR_WIDTH  write address
- mem_ce_o  out  1  write strobe
- mem_we_o  out  1  equals mem_ce_o

## Operation
- Accepted start: start_i=1 with busy_o=0. Start while busy is ignored. num_tiles_i=0 gives done_o the next cycle, with no reads or writes.
- Capture: lane 0 reads a tile for PE_SIZE consecutive cycles. Lane i repeats the same pattern delayed by i cycles through a shift-register skew line.
- Element (row r, lane i) is the rdata_i lane-i slice in the cycle rden_o[i] is high. It is written into bank b, row r, column i.
- Banks alternate per tile: tile k uses bank k%2.
- A bank is full at the end of the cycle in which lane PE_SIZE-1 makes its last read. Drain starts the next cycle.
- Drain: PE_SIZE cycles. Word r = bank row r, written to base + k*PE_SIZE + r, truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH).
- Capture of tile k+1 starts in the cycle after capture of tile k's lane 0 finishes. It may reuse a bank whose drain started in an earlier cycle, because row r is always read before it is overwritten. A capture never starts into a bank that is full but not yet draining.
- Buffer storage is not reset. All counters, enables, busy_o, done_o and mem_ce_o are reset.
- rst mid-operation aborts immediately. No further reads or writes occur, and the block is idle next cycle.
- Upstream FIFOs must hold each tile before start. No empty handling is provided.

## Timing
- Reset values: rden_o=0, mem_ce_o=0, mem_we_o=0, busy_o=0, done_o=0, mem_addr_o=0, mem_d_o=don't-care.
- Let N = tiles and P = PE_SIZE, with start accepted in cycle 0:
  - rden_o[i] for tile k: cycles 1+kP+i … kP+P+i.
  - mem_ce_o for tile k: cycles (k+2)P … (k+3)P-1, continuous across tiles.
  - Last write in cycle (N+2)P-1; done_o in cycle (N+2)P; busy_o low in that cycle.
- Control state: IDLE → RUN (capture counter active) → FLUSH (skew line and final drain) → DONE (1 cycle) → IDLE.

## Structure
- Shared package sa_mover_pkg holds the TILE_W and lane-slice helper constants, plus the state encoding (IDLE, RUN, FLUSH, DONE).
- Sub-module sa_skew_delay: a parametrised PE_SIZE-1 stage delay line for the enable and row-index pair. It drives rden_o and the per-lane buffer row index.
- The top level holds the two banks, capture/drain bank pointers, tile and row counters, and the address adder.

## Test plan
- P=4, N=1, base=0x10, lane data = row*16+lane → rden_o[0] high cycles 1–4 and rden_o[3] high cycles 4–7; writes in cycles 8–11 to 0x10–0x13, word r = {r*16+0, r*16+1, r*16+2, r*16+3}; done_o in cycle 12.
- P=4, N=3, distinct data per tile → mem_ce_o continuous in cycles 8–19, addresses base…base+11, no corruption across bank reuse; done_o in cycle 20.
- num_tiles_i=0 → done_o in cycle 1; rden_o and mem_ce_o never assert.
- P=4, ADDR_WIDTH=4, base=0xE, N=1 → addresses 0xE, 0xF, 0x0, 0x1.
- start_i pulsed again in cycle 5 of an N=1 run → ignored: one done_o, exactly 4 writes.
- rst in cycle 9 of an N=2 run → from cycle 10 all outputs at reset values; a new start then completes correctly.
